// File: rtl/ln_stage2_stats_if.sv
// ln_stage2_stats_if: handshake, vector and result bundle between LayerNorm stage 1, stage 2 and normalize
//   master drives i_en, i_valid and i_data_flat; slave returns o_ready, o_valid, o_raw_data_flat, o_mean and o_inv_sqrt
interface ln_stage2_stats_if;
  logic i_en;
  logic i_valid;
  logic o_ready;
  logic o_valid;
  logic [1023:0] i_data_flat;
  logic [1023:0] o_raw_data_flat;
  logic signed [31:0] o_mean;
  logic signed [16:0] o_inv_sqrt;
  modport master (
    output i_en, i_valid, i_data_flat,
    input  o_ready, o_valid, o_raw_data_flat, o_mean, o_inv_sqrt
  );
  modport slave (
    input  i_en, i_valid, i_data_flat,
    output o_ready, o_valid, o_raw_data_flat, o_mean, o_inv_sqrt
  );
endinterface

// File: rtl/ln_stage2_stats.sv
// ln_stage2_stats: mean and floor(1024/sqrt(var+EPS)) of a 64 x s16 vector, lane-parallel accumulate then bit-serial isqrt
//   i_clk, i_rstn (async active-low); bus.slave carries enable, input handshake/vector and the registered results
module ln_stage2_stats #(
  parameter int LANES = 4,
  parameter int EPS   = 1
) (
  input logic i_clk,
  input logic i_rstn,
  ln_stage2_stats_if.slave bus
);
  localparam int BEATS = 64 / LANES;
  typedef enum logic [2:0] {IDLE, ACCUM, VAR, ISQRT, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1023:0] vec_q, vec_d, raw_q, raw_d;
  logic signed [22:0] sum_q, sum_d;
  logic [37:0] sumsq_q, sumsq_d;
  logic signed [31:0] mean_q, mean_d, omean_q, omean_d;
  logic [31:0] d_q, d_d;
  logic [15:0] y_q, y_d, oinv_q, oinv_d;
  logic valid_q, valid_d;
  logic [5:0] idx;
  logic signed [15:0] e;
  logic signed [31:0] p;
  logic signed [22:0] lane_sum, msh;
  logic [37:0] lane_sq;
  logic signed [31:0] mean_c;
  logic signed [63:0] var_c;
  logic [31:0] d_c;
  logic [15:0] c;
  logic [63:0] prod;
  // idx wraps at 64 so the lane select stays in range while cnt_q holds the isqrt bit index
  always_comb begin
    lane_sum = '0;
    lane_sq = '0;
    idx = '0;
    e = '0;
    p = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = 6'(int'(cnt_q) * LANES + l);
      e = $signed(vec_q[{idx, 4'b0} +: 16]);
      p = e * e;
      lane_sum = lane_sum + {{7{e[15]}}, e};
      lane_sq = lane_sq + {6'b0, p};
    end
  end
  assign msh = sum_q >>> 6;
  assign mean_c = {{9{msh[22]}}, msh};
  assign var_c = $signed({32'b0, sumsq_q[37:6]}) - mean_c * mean_c;
  assign d_c = var_c < 0 ? 32'(EPS) : var_c[31:0] + 32'(EPS);
  assign c = y_q | (16'd1 << cnt_q[3:0]);
  assign prod = ({48'b0, c} * {48'b0, c}) * {32'b0, d_q};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    raw_d = raw_q;
    sum_d = sum_q;
    sumsq_d = sumsq_q;
    mean_d = mean_q;
    omean_d = omean_q;
    d_d = d_q;
    y_d = y_q;
    oinv_d = oinv_q;
    valid_d = state_q == DONE;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        vec_d = bus.i_data_flat;
        sum_d = '0;
        sumsq_d = '0;
        cnt_d = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        sum_d = sum_q + lane_sum;
        sumsq_d = sumsq_q + lane_sq;
        cnt_d = cnt_q + 6'd1;
        state_d = cnt_q == 6'(BEATS - 1) ? VAR : ACCUM;
      end
      VAR: begin
        mean_d = mean_c;
        d_d = d_c;
        y_d = '0;
        cnt_d = 6'd15;
        state_d = ISQRT;
      end
      ISQRT: begin
        y_d = prod <= 64'd1048576 ? c : y_q;
        cnt_d = cnt_q - 6'd1;
        state_d = cnt_q == 6'd0 ? DONE : ISQRT;
      end
      DONE: begin
        omean_d = mean_q;
        oinv_d = y_q;
        raw_d = vec_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_q <= '0;
      raw_q <= '0;
      sum_q <= '0;
      sumsq_q <= '0;
      mean_q <= '0;
      omean_q <= '0;
      d_q <= '0;
      y_q <= '0;
      oinv_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.i_en) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      raw_q <= raw_d;
      sum_q <= sum_d;
      sumsq_q <= sumsq_d;
      mean_q <= mean_d;
      omean_q <= omean_d;
      d_q <= d_d;
      y_q <= y_d;
      oinv_q <= oinv_d;
      valid_q <= valid_d;
    end
  end
  assign bus.o_ready = state_q == IDLE;
  assign bus.o_valid = valid_q;
  assign bus.o_mean = omean_q;
  assign bus.o_inv_sqrt = {1'b0, oinv_q};
  assign bus.o_raw_data_flat = raw_q;
endmodule

// File: tb/tb_ln_stage2_stats.sv
// tb_ln_stage2_stats: runs LANES=1/4/16 instances in lockstep against directed vectors and a reference model
module tb_ln_stage2_stats;
  localparam int EPS = 1;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic valid = 1'b0;
  logic [1023:0] data = '0;
  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  logic vld[3];
  logic rdy[3];
  logic [31:0] mean_w[3];
  logic [16:0] inv_w[3];
  logic [1023:0] raw_w[3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ln_stage2_stats_if bus ();
    assign bus.i_en = en;
    assign bus.i_valid = valid;
    assign bus.i_data_flat = data;
    assign vld[g] = bus.o_valid;
    assign rdy[g] = bus.o_ready;
    assign mean_w[g] = bus.o_mean;
    assign inv_w[g] = bus.o_inv_sqrt;
    assign raw_w[g] = bus.o_raw_data_flat;
    ln_stage2_stats #(.LANES(1 << (2 * g)), .EPS(EPS)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));
  end
  int ev_edge[3][32];
  logic [31:0] ev_mean[3][32];
  logic [16:0] ev_inv[3][32];
  logic [1023:0] ev_raw[3][32];
  int nev[3] = '{0, 0, 0};
  logic pv[3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !pv[i] && nev[i] < 32) begin
        ev_edge[i][nev[i]] <= ecnt;
        ev_mean[i][nev[i]] <= mean_w[i];
        ev_inv[i][nev[i]] <= inv_w[i];
        ev_raw[i][nev[i]] <= raw_w[i];
        nev[i] <= nev[i] + 1;
      end
      pv[i] <= vld[i];
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_raw(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low word %0h expected low word %0h", nm, act[63:0], exp[63:0]);
    end
  endtask
  function automatic void model(input logic [1023:0] v, output logic [31:0] m32, output logic [16:0] inv);
    longint s = 0, q = 0, m, vr, d, y, x;
    for (int k = 0; k < 64; k++) begin
      x = longint'($signed(v[16*k +: 16]));
      s += x;
      q += x * x;
    end
    m = s / 64;
    if (s % 64 != 0 && s < 0) m--;
    vr = q / 64 - m * m;
    if (vr < 0) vr = 0;
    d = vr + EPS;
    y = 0;
    while ((y + 1) * (y + 1) * d <= 1048576) y++;
    m32 = m[31:0];
    inv = y[16:0];
  endfunction
  function automatic logic [1023:0] mkvec(input int kind);
    logic [1023:0] v;
    for (int k = 0; k < 64; k++)
      v[16*k +: 16] = kind == 0 ? 16'sd1024 : kind == 1 ? ((k % 2) == 0 ? 16'sd256 : -16'sd256) :
                      kind == 2 ? 16'(k) : -16'sd1;
    return v;
  endfunction
  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s L%0d ready", tag, 1 << (2 * i)), 64'(rdy[i]), 64'd1);
      chk($sformatf("%s L%0d valid", tag, 1 << (2 * i)), 64'(vld[i]), 64'd0);
      chk($sformatf("%s L%0d mean", tag, 1 << (2 * i)), 64'(mean_w[i]), 64'd0);
      chk($sformatf("%s L%0d inv", tag, 1 << (2 * i)), 64'(inv_w[i]), 64'd0);
      chk_raw($sformatf("%s L%0d raw", tag, 1 << (2 * i)), raw_w[i], '0);
    end
  endtask
  task automatic run_vec(input string tag, input logic [1023:0] v, input int hold, input int stall,
                         input logic [31:0] xm, input logic [16:0] xi);
    int base[3];
    int acc, lat, cnt;
    for (int i = 0; i < 3; i++) base[i] = nev[i];
    data = v;
    valid = 1'b1;
    @(posedge clk);
    #1;
    acc = ecnt;
    data = ~v;
    for (int n = 0; n < 130; n++) begin
      en = !(stall > 0 && n >= stall && n < stall + 5);
      if (n >= hold) valid = 1'b0;
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt = nev[i] - base[i];
      lat = 64 / (1 << (2 * i)) + 18 + (stall > 0 ? 5 : 0);
      chk($sformatf("%s L%0d pulses", tag, 1 << (2 * i)), 64'(cnt), 64'd1);
      if (cnt >= 1) begin
        chk($sformatf("%s L%0d latency", tag, 1 << (2 * i)), 64'(ev_edge[i][base[i]] - acc), 64'(lat));
        chk($sformatf("%s L%0d mean", tag, 1 << (2 * i)), 64'(ev_mean[i][base[i]]), 64'(xm));
        chk($sformatf("%s L%0d inv", tag, 1 << (2 * i)), 64'(ev_inv[i][base[i]]), 64'(xi));
        chk_raw($sformatf("%s L%0d raw", tag, 1 << (2 * i)), ev_raw[i][base[i]], v);
      end
    end
  endtask
  typedef struct {
    int kind;
    logic [31:0] m;
    logic [16:0] inv;
    int hold;
    int stall;
  } vec_t;
  vec_t tab[5];
  initial begin
    logic [1023:0] v, a, b;
    logic [31:0] m;
    logic [16:0] iv;
    int base[3];
    int acc, acc2, b2;
    tab[0] = '{0, 32'd1024, 17'd1024, 0, 0};
    tab[1] = '{1, 32'd0, 17'd3, 0, 0};
    tab[2] = '{2, 32'd31, 17'd53, 0, 0};
    tab[3] = '{3, 32'hFFFFFFFF, 17'd1024, 10, 0};
    tab[4] = '{2, 32'd31, 17'd53, 0, 20};
    #1;
    check_reset("por");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 5; t++)
      run_vec($sformatf("tab%0d", t), mkvec(tab[t].kind), tab[t].hold, tab[t].stall, tab[t].m, tab[t].inv);
    for (int i = 0; i < 3; i++) base[i] = nev[i];
    data = mkvec(0);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("midrst L%0d no pulse", 1 << (2 * i)), 64'(nev[i] - base[i]), 64'd0);
    a = mkvec(2);
    b = mkvec(1);
    for (int i = 0; i < 3; i++) base[i] = nev[i];
    data = a;
    valid = 1'b1;
    @(posedge clk);
    #1;
    acc = ecnt;
    valid = 1'b0;
    for (int n = 0; n < 60 && !vld[1]; n++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b first latency", 64'(ecnt - acc), 64'd34);
    chk("b2b ready with valid", 64'(rdy[1]), 64'd1);
    chk("b2b mean during pulse", 64'(mean_w[1]), 64'd31);
    data = b;
    valid = 1'b1;
    @(posedge clk);
    #1;
    acc2 = ecnt;
    valid = 1'b0;
    chk("b2b accepted", 64'(rdy[1]), 64'd0);
    chk("b2b pulse ended", 64'(vld[1]), 64'd0);
    chk("b2b mean held", 64'(mean_w[1]), 64'd31);
    chk("b2b inv held", 64'(inv_w[1]), 64'd53);
    repeat (100) @(posedge clk);
    #1;
    chk("b2b L4 pulses", 64'(nev[1] - base[1]), 64'd2);
    chk("b2b L1 pulses", 64'(nev[0] - base[0]), 64'd1);
    if (nev[1] - base[1] >= 2) begin
      b2 = base[1] + 1;
      chk("b2b second latency", 64'(ev_edge[1][b2] - acc2), 64'd34);
      chk("b2b second mean", 64'(ev_mean[1][b2]), 64'd0);
      chk("b2b second inv", 64'(ev_inv[1][b2]), 64'd3);
    end
    for (int r = 0; r < 16; r++) begin
      int bs;
      bs = int'($urandom_range(0, 2000)) - 1000;
      for (int k = 0; k < 64; k++) begin
        case (r % 4)
          0: v[16*k +: 16] = 16'($urandom);
          1: v[16*k +: 16] = 16'(bs + int'($urandom_range(0, 16)) - 8);
          2: v[16*k +: 16] = 16'(bs * 30);
          default: v[16*k +: 16] = $urandom_range(0, 2) == 0 ? 16'h8000 :
                                   $urandom_range(0, 1) == 0 ? 16'h7FFF : 16'($urandom);
        endcase
      end
      model(v, m, iv);
      run_vec($sformatf("rnd%0d", r), v, 0, 0, m, iv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
